// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Hazard and sequencing controller for a 5-stage pipeline. It decodes load-use
// stalls, taken-branch squashes, multi-cycle EX operations and data-memory wait
// states into enable/flush controls for the PC, IF/ID, ID/EX and EX/MEM stages.
// State (RUN / MC_BUSY plus a down-counter) is registered. Outputs are a
// combinational decode of the current state and inputs.
//
// Optional feature macro: PIPE_HAZARD_PERF_CNT_EN
//   defined   -> stall_cycles is a saturating 16-bit count of non-reset cycles
//                in which the PC is held (pc_en=0)
//   undefined -> stall_cycles is tied to zero and no counter is built
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int MC_LATENCY     = 4,   // legal range 1..16
    parameter int CNT_WIDTH      = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_ADDR_WIDTH-1:0] id_rs,
    input  logic [REG_ADDR_WIDTH-1:0] id_rt,
    input  logic                      id_uses_rs,
    input  logic                      id_uses_rt,
    input  logic                      id_is_mc,
    input  logic                      ex_is_load,
    input  logic                      ex_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
    input  logic                      branch_taken,
    input  logic                      mem_stall,
    output logic                      pc_en,
    output logic                      ifid_en,
    output logic                      ifid_flush,
    output logic                      idex_en,
    output logic                      idex_flush,
    output logic                      exmem_flush,
    output logic                      mc_start,
    output logic                      mc_done,
    output logic                      busy,
    output logic [15:0]               stall_cycles
);

    typedef enum logic {
        RUN     = 1'b0,
        MC_BUSY = 1'b1
    } state_t;

    // Counter reload so that the op spends exactly MC_LATENCY cycles in EX:
    // MC_LATENCY-1 counting cycles followed by the cnt==0 (mc_done) cycle.
    localparam logic [CNT_WIDTH-1:0] MC_LOAD = CNT_WIDTH'(MC_LATENCY - 1);

    state_t                 state_reg;
    state_t                 state_next;
    logic [CNT_WIDTH-1:0]   cnt_reg;
    logic [CNT_WIDTH-1:0]   cnt_next;

    logic                   rs_match;
    logic                   rt_match;
    logic                   load_use;

    // Load-use detection: a load in EX targeting a non-zero register that the
    // ID instruction reads. Register 0 is hardwired, so it never hazards.
    always_comb begin
        rs_match = id_uses_rs && (id_rs == ex_rd);
        rt_match = id_uses_rt && (id_rt == ex_rd);
        load_use = ex_is_load && ex_reg_write && (ex_rd != '0) && (rs_match || rt_match);
    end

    // Next-state and output decode, highest priority first:
    // reset > mem_stall > MC_BUSY > branch_taken > load-use > mc start.
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idex_en     = 1'b1;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        mc_start    = 1'b0;
        mc_done     = 1'b0;
        busy        = (state_reg == MC_BUSY);
        state_next  = state_reg;
        cnt_next    = cnt_reg;

        if (rst) begin
            // Bubble every stage and abandon any multi-cycle op silently.
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            busy        = 1'b0;
            state_next  = RUN;
            cnt_next    = '0;
        end else if (mem_stall) begin
            // Whole pipeline frozen; state and counter hold.
            pc_en   = 1'b0;
            ifid_en = 1'b0;
            idex_en = 1'b0;
        end else if (state_reg == MC_BUSY) begin
            if (cnt_reg != '0) begin
                // Op still occupies EX: hold the front end, bubble into MEM.
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                idex_en     = 1'b0;
                exmem_flush = 1'b1;
                cnt_next    = cnt_reg - 1'b1;
            end else begin
                // Final EX cycle: result flows on; a waiting mc op starts later.
                mc_done    = 1'b1;
                state_next = RUN;
            end
        end else if (branch_taken) begin
            // Squash the wrong-path instructions in IF/ID and ID/EX.
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use) begin
            // One-cycle stall; the load reaches MEM and forwarding covers it.
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end else if (id_is_mc) begin
            mc_start   = 1'b1;
            state_next = MC_BUSY;
            cnt_next   = MC_LOAD;
        end
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= RUN;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

`ifdef PIPE_HAZARD_PERF_CNT_EN
    logic [15:0] stall_cnt_reg;

    // Saturating count of cycles in which the PC did not advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_reg <= '0;
        end else if (!pc_en && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end

    assign stall_cycles = stall_cnt_reg;
`else
    assign stall_cycles = '0;
`endif

endmodule
